// File: rtl/vga_mem_arb_pkg.sv
// Shared types and the round-robin pick helper for the VGA memory arbiter.
package vga_mem_arb_pkg;

    localparam int MAX_REQ        = 8;
    localparam int PTR_MAX_W      = 3;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;

    typedef logic [DEF_ADDR_WIDTH-1:0] mem_addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] mem_data_t;

    // Rotate by ptr, take the lowest set bit, rotate back: first requester at or above ptr wins.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0]   req,
                                                   input logic [PTR_MAX_W-1:0] ptr,
                                                   input int                   n);
        logic [MAX_REQ-1:0]   gnt;
        logic [PTR_MAX_W-1:0] idx;
        logic                 found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = PTR_MAX_W'((i + int'(ptr)) % n);
            if (i < n && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/vga_mem_arbiter_sva.sv
// Protocol and fairness properties for vga_mem_arbiter, attached by bind.
module vga_mem_arbiter_sva #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input logic                          clk_i,
    input logic                          arst_n_i,
    input logic [NUM_REQ-1:0]            req_i,
    input logic [NUM_REQ-1:0]            urgent_i,
    input logic [NUM_REQ-1:0]            we_i,
    input logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    input logic [NUM_REQ-1:0]            gnt_o,
    input logic [NUM_REQ-1:0]            rvalid_o
);

    logic       any_urg;
    logic [7:0] wait_q [NUM_REQ];

    assign any_urg = |(req_i & urgent_i);

    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!arst_n_i) $onehot0(gnt_o));
    a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (!arst_n_i) $onehot0(rvalid_o));
    a_rvalid_lat: assert property (@(posedge clk_i) disable iff (!arst_n_i)
        1'b1 |=> (rvalid_o == $past(gnt_o & ~we_i)));

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        a_payload_stable: assert property (@(posedge clk_i) disable iff (!arst_n_i)
            (arst_n_i && req_i[i] && !gnt_o[i]) |=> (!req_i[i] ||
                ($stable(we_i[i]) &&
                 $stable(addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                 $stable(wdata_i[i*DATA_WIDTH +: DATA_WIDTH]))));

        // Cycles spent waiting while no urgent traffic competes.
        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                wait_q[i] <= '0;
            end else if (req_i[i] && !gnt_o[i] && !any_urg && wait_q[i] != 8'hFF) begin
                wait_q[i] <= wait_q[i] + 8'd1;
            end else begin
                wait_q[i] <= '0;
            end
        end

        a_fair: assert property (@(posedge clk_i) disable iff (!arst_n_i)
            int'(wait_q[i]) < NUM_REQ);
    end

endmodule

bind vga_mem_arbiter vga_mem_arbiter_sva #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
) u_sva (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .req_i    (req_i),
    .urgent_i (urgent_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o)
);

// File: rtl/vga_rr_picker.sv
// Combinational round-robin picker over NUM_REQ requesters starting at ptr_i.
module vga_rr_picker
    import vga_mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] gnt_ext;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req_i;
        gnt_ext                = rr_pick(req_ext, PTR_MAX_W'(ptr_i), NUM_REQ);
    end

    assign gnt_o = gnt_ext[NUM_REQ-1:0];

    if (NUM_REQ < MAX_REQ) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^gnt_ext[MAX_REQ-1:NUM_REQ];
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port memory arbiter: urgent-class-first round-robin, 1-cycle read return.
module vga_mem_arbiter
    import vga_mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          arst_n_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            urgent_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          mem_en_o,
    output logic                          mem_we_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [NUM_REQ-1:0] urg_req;
    logic [NUM_REQ-1:0] gnt_urg;
    logic [NUM_REQ-1:0] gnt_all;
    logic               any_urg;

    assign urg_req = req_i & urgent_i;
    assign any_urg = |urg_req;

    vga_rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick_urg (
        .req_i (urg_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt_urg)
    );

    vga_rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick_all (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt_all)
    );

    // Grant is forced off while reset is held so no access leaks out during reset.
    assign gnt_o = !arst_n_i ? '0 : (any_urg ? gnt_urg : gnt_all);

    always_comb begin
        mem_en_o    = |gnt_o;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        rr_ptr_d    = rr_ptr_q;
        rvalid_d    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_o[i]) begin
                mem_we_o    = we_i[i];
                mem_addr_o  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata_o = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                rr_ptr_d    = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
                rvalid_d[i] = ~we_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rr_ptr_q <= '0;
            rvalid_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = (|rvalid_q) ? mem_rdata_i : '0;

endmodule
